// File: rtl/if_id_fetch.sv
// Fetch stage with PC register, next-PC select and the IF/ID pipeline register.
// Latency: the instruction word at imem_addr appears on instr_id one cycle later.
// Backpressure: stall freezes the PC and IF/ID, flush loads a bubble, and a branch redirect overrides stall.
module if_id_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h910003FF,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_taken,
    input  logic [63:0]      br_target,
    output logic [31:0]      instr_id,
    output logic [63:0]      pc_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] bubble_count
);

    logic [63:0]      pc_q,           pc_d;
    logic [31:0]      instr_id_q,     instr_id_d;
    logic [63:0]      pc_id_q,        pc_id_d;
    logic             valid_id_q,     valid_id_d;
    logic [CNT_W-1:0] instr_count_q,  instr_count_d;
    logic [CNT_W-1:0] bubble_count_q, bubble_count_d;

    // Next PC: a redirect beats stall, so a branch resolved during a stall still steers fetch.
    always_comb begin
        pc_d = pc_q + 64'd4;
        if (br_taken) begin
            pc_d = {br_target[63:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // IF/ID next state: flush beats stall; a branch alone leaves the delay-slot word in place.
    always_comb begin
        instr_id_d     = instr_id_q;
        pc_id_d        = pc_id_q;
        valid_id_d     = valid_id_q;
        instr_count_d  = instr_count_q;
        bubble_count_d = bubble_count_q;
        if (flush) begin
            instr_id_d     = NOP_INSTR;
            pc_id_d        = pc_q;
            valid_id_d     = 1'b0;
            bubble_count_d = bubble_count_q + 1'b1;
        end else if (!stall) begin
            instr_id_d     = imem_data;
            pc_id_d        = pc_q;
            valid_id_d     = 1'b1;
            instr_count_d  = instr_count_q + 1'b1;
        end
    end

    // State registers; reset discards any redirect or flush presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            instr_id_q     <= NOP_INSTR;
            pc_id_q        <= 64'h0;
            valid_id_q     <= 1'b0;
            instr_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            pc_q           <= pc_d;
            instr_id_q     <= instr_id_d;
            pc_id_q        <= pc_id_d;
            valid_id_q     <= valid_id_d;
            instr_count_q  <= instr_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign imem_addr    = pc_q;
    assign instr_id     = instr_id_q;
    assign pc_id        = pc_id_q;
    assign valid_id     = valid_id_q;
    assign instr_count  = instr_count_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_if_id_fetch.sv
module tb_if_id_fetch;

    localparam logic [31:0] NOP = 32'h910003FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = 64'h0;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_id;
    logic [63:0] pc_id;
    logic        valid_id;
    logic [31:0] instr_count;
    logic [31:0] bubble_count;

    // Second instance: high reset PC for the address wrap, 2-bit counters for counter wrap.
    logic        w_reset = 1'b1;
    logic        w_flush = 1'b0;
    logic [63:0] w_addr;
    logic [31:0] w_data;
    logic [31:0] w_instr;
    logic [63:0] w_pcid;
    logic        w_valid;
    logic [1:0]  w_icnt;
    logic [1:0]  w_bcnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h8B000000 | a[31:0];
    endfunction

    assign imem_data = mem_word(imem_addr);
    assign w_data    = mem_word(w_addr);

    if_id_fetch u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
        .instr_id(instr_id), .pc_id(pc_id), .valid_id(valid_id),
        .instr_count(instr_count), .bubble_count(bubble_count)
    );

    if_id_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .CNT_W(2)) u_wrap (
        .clk(clk), .reset(w_reset), .imem_addr(w_addr), .imem_data(w_data),
        .stall(1'b0), .flush(w_flush), .br_taken(1'b0), .br_target(64'h0),
        .instr_id(w_instr), .pc_id(w_pcid), .valid_id(w_valid),
        .instr_count(w_icnt), .bubble_count(w_bcnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, stl, fls, br;
        logic [63:0] tgt;
        logic [63:0] e_addr;
        logic [31:0] e_instr;
        logic [63:0] e_pcid;
        logic        e_valid;
        logic [31:0] e_icnt, e_bcnt;
    } vec_t;

    vec_t vecs[16];

    // Reference model state
    logic [63:0] m_pc, m_pcid;
    logic [31:0] m_instr, m_icnt, m_bcnt;
    logic        m_valid;

    task automatic model_step(input logic r, input logic s, input logic f,
                              input logic b, input logic [63:0] t);
        logic [63:0] npc;
        if (r) begin
            m_pc = 64'h0; m_instr = NOP; m_pcid = 64'h0; m_valid = 1'b0;
            m_icnt = 0; m_bcnt = 0;
        end else begin
            if (b)      npc = t - (t % 4);
            else if (s) npc = m_pc;
            else        npc = m_pc + 4;
            if (f) begin
                m_instr = NOP; m_pcid = m_pc; m_valid = 1'b0; m_bcnt = m_bcnt + 1;
            end else if (!s) begin
                m_instr = mem_word(m_pc); m_pcid = m_pc; m_valid = 1'b1; m_icnt = m_icnt + 1;
            end
            m_pc = npc;
        end
    endtask

    initial begin
        //         rst  stl  fls  br   tgt         addr        instr         pcid        v     ic  bc
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,64'h0,   64'h0,   NOP,          64'h0,   1'b0, 0, 0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h4,   32'h8B000000, 64'h0,   1'b1, 1, 0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h8,   32'h8B000004, 64'h4,   1'b1, 2, 0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,64'h0,   64'h8,   32'h8B000004, 64'h4,   1'b1, 2, 0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,64'h0,   64'h8,   32'h8B000004, 64'h4,   1'b1, 2, 0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'hC,   32'h8B000008, 64'h8,   1'b1, 3, 0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h10,  32'h8B00000C, 64'hC,   1'b1, 4, 0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,64'h103, 64'h100, 32'h8B000010, 64'h10,  1'b1, 5, 0};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h104, 32'h8B000100, 64'h100, 1'b1, 6, 0};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,64'h0,   64'h104, NOP,          64'h104, 1'b0, 6, 1};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,64'h0,   64'h108, NOP,          64'h104, 1'b0, 6, 2};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b1,64'h202, 64'h200, NOP,          64'h104, 1'b0, 6, 2};
        vecs[12] = '{1'b0,1'b0,1'b1,1'b1,64'h41,  64'h40,  NOP,          64'h200, 1'b0, 6, 3};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h44,  32'h8B000040, 64'h40,  1'b1, 7, 3};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b1,64'h500, 64'h0,   NOP,          64'h0,   1'b0, 0, 0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,64'h0,   64'h4,   32'h8B000000, 64'h0,   1'b1, 1, 0};

        for (int i = 0; i < 16; i++) begin
            reset = vecs[i].rst; stall = vecs[i].stl; flush = vecs[i].fls;
            br_taken = vecs[i].br; br_target = vecs[i].tgt;
            if (i == 0) w_reset = 1'b1;
            else        w_reset = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d instr_id", i), {32'h0, instr_id}, {32'h0, vecs[i].e_instr});
            chk($sformatf("v%0d pc_id", i), pc_id, vecs[i].e_pcid);
            chk($sformatf("v%0d valid_id", i), {63'h0, valid_id}, {63'h0, vecs[i].e_valid});
            chk($sformatf("v%0d instr_count", i), {32'h0, instr_count}, {32'h0, vecs[i].e_icnt});
            chk($sformatf("v%0d bubble_count", i), {32'h0, bubble_count}, {32'h0, vecs[i].e_bcnt});
            // Wrap instance free-runs: edge i leaves PC at FFF8 + 4*i modulo 2^64.
            chk($sformatf("wrap%0d imem_addr", i), w_addr, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i));
            chk($sformatf("wrap%0d instr_count", i), {62'h0, w_icnt}, 64'(i % 4));
        end

        // Five flushes on the 2-bit bubble counter wrap it back to 1.
        w_flush = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        w_flush = 1'b0;
        chk("wrap bubble_count", {62'h0, w_bcnt}, 64'h1);
        chk("wrap valid_id after flush", {63'h0, w_valid}, 64'h0);

        // Randomized run against the reference model.
        for (int i = 0; i < 600; i++) begin
            reset     = (i == 0) || ($urandom_range(0, 49) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 5) == 0);
            br_taken  = ($urandom_range(0, 4) == 0);
            br_target = {$urandom, $urandom};
            model_step(reset, stall, flush, br_taken, br_target);
            @(posedge clk); #1;
            chk("rnd imem_addr", imem_addr, m_pc);
            chk("rnd instr_id", {32'h0, instr_id}, {32'h0, m_instr});
            chk("rnd pc_id", pc_id, m_pcid);
            chk("rnd valid_id", {63'h0, valid_id}, {63'h0, m_valid});
            chk("rnd instr_count", {32'h0, instr_count}, {32'h0, m_icnt});
            chk("rnd bubble_count", {32'h0, bubble_count}, {32'h0, m_bcnt});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
